// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC sequencer slice.
package mac_pkg;

    localparam int LANE_W    = 16;
    localparam int OP_W      = 8;
    localparam int MAC_OUT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/mac_sequencer_if.sv
// Job, operand-stream, MAC and result signals of the sequencer.
// The slave modport is the sequencer's view; the master modport is the view
// of the environment around it (job source, operand source, MAC, result sink).
interface mac_sequencer_if
    import mac_pkg::*;
#(
    parameter int N     = 4,
    parameter int LW    = 8,
    parameter int ACC_W = 24
);

    logic                  start;
    logic [LW-1:0]         len;
    logic                  busy;
    logic                  in_valid;
    logic                  in_ready;
    logic [OP_W-1:0]       in_a;
    logic [OP_W-1:0]       in_b;
    logic [LANE_W*N-1:0]   mac_in;
    logic [MAC_OUT_W-1:0]  mac_out;
    logic                  res_valid;
    logic                  res_ready;
    logic [ACC_W-1:0]      res_data;

    modport master (
        output start, len, in_valid, in_a, in_b, mac_out, res_ready,
        input  busy, in_ready, mac_in, res_valid, res_data
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, mac_out, res_ready,
        output busy, in_ready, mac_in, res_valid, res_data
    );

endinterface

// File: rtl/mac_valid_pipe.sv
// DEPTH-deep 1-bit delay line tagging which MAC cycles carry a real result.
// valid_o is the tag leaving the line this cycle; pending_o reports tags that
// will still be in flight after this cycle.
module mac_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic clear_i,
    input  logic push_i,
    output logic valid_o,
    output logic pending_o
);

    logic [DEPTH-1:0] tag_q;
    logic [DEPTH-1:0] tag_d;

    generate
        if (DEPTH == 1) begin : g_single
            assign tag_d     = push_i;
            assign pending_o = 1'b0;
        end else begin : g_multi
            assign tag_d     = {tag_q[DEPTH-2:0], push_i};
            assign pending_o = |tag_q[DEPTH-2:0];
        end
    endgenerate

    assign valid_o = tag_q[DEPTH-1];

    // Shift the tags one stage per cycle; clear drops everything in flight.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// Packs streamed operand pairs N at a time into one external MAC and sums the
// returned partial products into a wide dot-product result.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int N       = 4,
    parameter int MAC_LAT = 1,
    parameter int LW      = 8,
    parameter int ACC_W   = 24
) (
    input logic           clk,
    input logic           rst,
    mac_sequencer_if.slave bus
);

    localparam int               IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_e                   state_q, state_d;
    logic [LW-1:0]            remaining_q, remaining_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [N-1:0][LANE_W-1:0] lanes_q, lanes_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic                     accept;
    logic                     issue;
    logic                     tagValid;
    logic                     tagPending;

    assign accept = (state_q == FILL) && bus.in_valid;

    mac_valid_pipe #(
        .DEPTH(MAC_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .clear_i  (rst),
        .push_i   (issue),
        .valid_o  (tagValid),
        .pending_o(tagPending)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a group closes when the last lane fills or the job runs out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = (bus.len != '0) ? FILL : DONE;
                end
            end
            FILL: begin
                if (accept && ((idx_q == LAST_IDX) || (remaining_q == LW'(1)))) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = (remaining_q != '0) ? FILL : DRAIN;
            end
            DRAIN: begin
                if (!tagPending) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state; mac_in is quiet except in ISSUE.
    always_comb begin
        issue         = (state_q == ISSUE);
        bus.busy      = (state_q != IDLE);
        bus.in_ready  = (state_q == FILL);
        bus.res_valid = (state_q == DONE);
        bus.mac_in    = issue ? lanes_q : '0;
    end

    assign bus.res_data = acc_q;

    // Datapath next values: lane packing, job countdown and accumulation.
    always_comb begin
        remaining_d = remaining_q;
        idx_d       = idx_q;
        lanes_d     = lanes_q;
        acc_d       = acc_q;
        if (tagValid) begin
            acc_d = acc_q + ACC_W'(bus.mac_out);
        end
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    remaining_d = bus.len;
                    acc_d       = '0;
                end
            end
            FILL: begin
                if (accept) begin
                    lanes_d[idx_q] = {bus.in_b, bus.in_a};
                    idx_d          = idx_q + IDX_W'(1);
                    remaining_d    = remaining_q - LW'(1);
                end
            end
            ISSUE: begin
                lanes_d = '0;
                idx_d   = '0;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_q <= '0;
            idx_q       <= '0;
            lanes_q     <= '0;
            acc_q       <= '0;
        end else begin
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            lanes_q     <= lanes_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: directed vectors, a reset-abort
// sequence and randomized jobs checked against a plain dot-product model.
module tb_mac_sequencer;

    localparam int N       = 4;
    localparam int MAC_LAT = 1;
    localparam int LW      = 8;
    localparam int ACC_W   = 24;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [7:0]  opA [256];
    logic [7:0]  opB [256];
    logic [63:0] issueQ [$];
    logic [15:0] macPipe [MAC_LAT];

    mac_sequencer_if #(.N(N), .LW(LW), .ACC_W(ACC_W)) bus ();

    mac_sequencer #(
        .N(N), .MAC_LAT(MAC_LAT), .LW(LW), .ACC_W(ACC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External MAC model: sum of N unsigned 8x8 products, mod 2^16, MAC_LAT registers deep.
    function automatic logic [15:0] macSum(input logic [63:0] w);
        int s;
        s = 0;
        for (int k = 0; k < N; k++) begin
            s += int'(w[16*k +: 8]) * int'(w[16*k+8 +: 8]);
        end
        return s[15:0];
    endfunction

    always @(posedge clk) begin
        macPipe[0] <= macSum(bus.mac_in);
        for (int i = 1; i < MAC_LAT; i++) begin
            macPipe[i] <= macPipe[i-1];
        end
    end
    assign bus.mac_out = macPipe[MAC_LAT-1];

    // Record every word the sequencer hands to the MAC.
    always @(negedge clk) begin
        if (bus.mac_in != '0) begin
            issueQ.push_back(bus.mac_in);
        end
    end

    // Reference: group pairs N at a time, truncate each group to 16 bits, sum mod 2^24.
    function automatic logic [23:0] expectDot(input int len);
        longint acc;
        int     s;
        acc = 0;
        for (int g = 0; g < len; g += N) begin
            s = 0;
            for (int k = 0; (k < N) && (g + k < len); k++) begin
                s += int'(opA[g+k]) * int'(opB[g+k]);
            end
            acc = (acc + (s % 65536)) % (64'd1 << ACC_W);
        end
        return acc[23:0];
    endfunction

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic resetDut();
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;
        stepClk();
        stepClk();
        rst = 1'b0;
    endtask

    // Run one job from IDLE. vmode: 0 continuous, 1 every other cycle, 2 random.
    // disturb keeps start high and drives junk pairs whenever none are owed.
    task automatic applyStimulus(input int len, input int vmode, input int readyDelay,
                                 input bit disturb, output logic [23:0] result,
                                 output int doneCycle);
        int cyc;
        int idx;
        bit take;
        bit seen;
        bit v;
        issueQ.delete();
        result    = '0;
        doneCycle = -1;
        seen      = 1'b0;
        bus.start = 1'b1;
        bus.len   = LW'(len);
        stepClk();
        cyc       = 1;
        idx       = 0;
        bus.start = 1'b0;
        while (cyc < 3000) begin
            if (bus.res_valid) begin
                seen = 1'b1;
                break;
            end
            case (vmode)
                0:       v = (idx < len);
                1:       v = (cyc % 2 == 1) && (idx < len);
                default: v = ($urandom_range(0, 1) == 1) && (idx < len);
            endcase
            if (disturb) begin
                bus.start = 1'b1;
                if (idx >= len) v = 1'b1;
            end
            bus.in_valid = v;
            bus.in_a     = (idx < len) ? opA[idx] : 8'hEE;
            bus.in_b     = (idx < len) ? opB[idx] : 8'hEE;
            take         = v && bus.in_ready && (idx < len);
            stepClk();
            cyc++;
            if (take) idx++;
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("job completes", 64'(seen), 64'd1);
        if (!seen) begin
            resetDut();
            return;
        end
        doneCycle = cyc;
        result    = bus.res_data;
        checkOutput("pairs consumed", 64'(idx), 64'(len));
        for (int k = 0; k < readyDelay; k++) begin
            stepClk();
            checkOutput("res_valid held", 64'(bus.res_valid), 64'd1);
            checkOutput("res_data stable", 64'(bus.res_data), 64'(result));
        end
        bus.res_ready = 1'b1;
        stepClk();
        bus.res_ready = 1'b0;
        checkOutput("idle after ready", 64'(bus.busy), 64'd0);
        checkOutput("res_data kept in idle", 64'(bus.res_data), 64'(result));
    endtask

    typedef struct {
        int          len;
        int          vmode;
        int          readyDelay;
        bit          disturb;
        logic [63:0] aPack;
        logic [63:0] bPack;
        logic [23:0] expRes;
        int          expDone;
        int          expIssues;
        logic [63:0] expFirst;
        logic [63:0] expLast;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [23:0] res;
        int          done;
        int          rlen;

        vecs[0] = '{4, 0, 0, 1'b0, 64'h0000_0000_AB03_AB03, 64'h0000_0000_0206_0206,
                    24'd720, 7, 1, 64'h02AB_0603_02AB_0603, 64'h02AB_0603_02AB_0603};
        vecs[1] = '{6, 0, 0, 1'b0, 64'h0000_02AB_0308_FFFF, 64'h0000_0202_0605_FFFF,
                    24'd64918, 10, 2, 64'h0603_0508_FFFF_FFFF, 64'h0000_0000_0202_02AB};
        vecs[2] = '{0, 0, 0, 1'b0, 64'h0, 64'h0,
                    24'd0, 1, 0, 64'h0, 64'h0};
        vecs[3] = '{5, 1, 3, 1'b0, 64'h0000_0009_0705_0301, 64'h0000_000A_0806_0402,
                    24'd190, 12, 2, 64'h0807_0605_0403_0201, 64'h0000_0000_0000_0A09};
        vecs[4] = '{6, 0, 0, 1'b1, 64'h0000_02AB_0308_FFFF, 64'h0000_0202_0605_FFFF,
                    24'd64918, 10, 2, 64'h0603_0508_FFFF_FFFF, 64'h0000_0000_0202_02AB};

        resetDut();
        checkOutput("reset busy", 64'(bus.busy), 64'd0);
        checkOutput("reset in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("reset res_valid", 64'(bus.res_valid), 64'd0);
        checkOutput("reset mac_in", bus.mac_in, 64'd0);
        checkOutput("reset res_data", 64'(bus.res_data), 64'd0);

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 8; j++) begin
                opA[j] = vecs[i].aPack[8*j +: 8];
                opB[j] = vecs[i].bPack[8*j +: 8];
            end
            applyStimulus(vecs[i].len, vecs[i].vmode, vecs[i].readyDelay,
                          vecs[i].disturb, res, done);
            checkOutput($sformatf("vec%0d res_data", i), 64'(res), 64'(vecs[i].expRes));
            checkOutput($sformatf("vec%0d done cycle", i), 64'(done), 64'(vecs[i].expDone));
            checkOutput($sformatf("vec%0d issue count", i), 64'(issueQ.size()),
                        64'(vecs[i].expIssues));
            if (vecs[i].expIssues > 0 && issueQ.size() > 0) begin
                checkOutput($sformatf("vec%0d first mac_in", i), issueQ[0], vecs[i].expFirst);
                checkOutput($sformatf("vec%0d last mac_in", i), issueQ[$], vecs[i].expLast);
            end
        end

        // Reset one cycle after the first ISSUE of a len=8 job; its MAC result must be dropped.
        for (int j = 0; j < 8; j++) begin
            opA[j] = 8'hFF;
            opB[j] = 8'hFF;
        end
        bus.start = 1'b1;
        bus.len   = LW'(8);
        stepClk();
        bus.start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = opA[j];
            bus.in_b     = opB[j];
            stepClk();
        end
        bus.in_valid = 1'b0;
        stepClk();
        rst = 1'b1;
        stepClk();
        rst = 1'b0;
        checkOutput("abort busy", 64'(bus.busy), 64'd0);
        checkOutput("abort in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("abort res_valid", 64'(bus.res_valid), 64'd0);
        checkOutput("abort mac_in", bus.mac_in, 64'd0);
        checkOutput("abort res_data", 64'(bus.res_data), 64'd0);
        stepClk();
        checkOutput("abort res_data later", 64'(bus.res_data), 64'd0);
        opA[0] = 8'h03;
        opB[0] = 8'h06;
        applyStimulus(1, 0, 0, 1'b0, res, done);
        checkOutput("post-abort res_data", 64'(res), 64'd18);

        // Randomized jobs, including the maximum length.
        for (int t = 0; t < 20; t++) begin
            rlen = (t == 19) ? 255 : int'($urandom_range(0, 40));
            for (int j = 0; j < rlen; j++) begin
                opA[j] = 8'($urandom);
                opB[j] = 8'($urandom);
            end
            applyStimulus(rlen, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), res, done);
            checkOutput($sformatf("random job %0d len %0d res_data", t, rlen),
                        64'(res), 64'(expectDot(rlen)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Sequences one shared N-lane multiply-accumulate datapath (mult_accumulate, 16*N-bit packed operand input, 16-bit sum-of-products output) to compute dot products of arbitrary length.
- Accepts a job length, then streams 8-bit operand pairs in one pair per cycle and packs them N at a time into the MAC input word.
- Accumulates the returned 16-bit partial sums into a wide result and presents that result on a valid/ready output.
- Sits between the operand source and the MAC instance; the MAC itself is external.

Parameters:
- N, 4, number of MAC lanes (pairs per issued word)
- MAC_LAT, 1, cycles from mac_in presented to matching mac_out valid (>=1)
- LW, 8, width of len (job length 0..2^LW-1 pairs)
- ACC_W, 24, result accumulator width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  job request, sampled in IDLE only
- len  in  LW  number of operand pairs in job, sampled with start
- busy  out  1  high in every state except IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  high in FILL only
- in_a  in  8  operand A, unsigned
- in_b  in  8  operand B, unsigned
- mac_in  out  16*N  packed word to MAC; lane k: a at [16k+7:16k], b at [16k+15:16k+8]
- mac_out  in  16  MAC sum of N products (mod 2^16)
- res_valid  out  1  result valid (DONE state)
- res_ready  in  1  result consumed
- res_data  out  ACC_W  accumulated dot product

Behaviour:
- Reset: state IDLE; busy, in_ready, res_valid = 0; mac_in = 0; res_data = 0; lane buffer, lane index, remaining count and valid-tag pipe cleared. Reset mid-job aborts it; mac_out returning after reset is ignored.
- IDLE:
  - start && len!=0: latch len into remaining, clear acc, go to FILL.
  - start && len==0: clear acc, go directly to DONE (res_data=0).
- FILL:
  - in_ready=1. Each in_valid&&in_ready writes the pair into lane idx, then idx++ and remaining--.
  - Go to ISSUE the cycle after lane N-1 is written or remaining reaches 0.
  - in_valid low: hold state, no change.
- ISSUE (1 cycle):
  - mac_in = lane buffer; lanes not written this group are 0, so they contribute a 0 product. mac_in = 0 in all other states.
  - Push 1 into the tag pipe; clear the lane buffer and idx.
  - Next state: FILL if remaining>0, else DRAIN.
- Tag pipe: MAC_LAT-deep shift register. When its output bit is 1 in a cycle, acc <= acc + zero-extend(mac_out) at the end of that cycle. acc wraps mod 2^ACC_W.
- DRAIN: stay until the tag pipe holds no 1 (including the bit used this cycle), then go to DONE.
- DONE:
  - res_valid=1, res_data=acc, held stable while res_ready is low.
  - res_ready high: return to IDLE next cycle; res_data holds its last value.
- start outside IDLE is ignored. in_valid outside FILL is ignored (in_ready=0, no pair consumed).
- Timing: start sampled in cycle 0; with continuous in_valid, pairs are accepted in cycles 1..N and ISSUE occurs in cycle N+1. For len<=N, res_valid rises in cycle N+MAC_LAT+2. Throughput is N+1 cycles per full group.

Decomposition:
- Package mac_pkg: FSM state enum (IDLE, FILL, ISSUE, DRAIN, DONE), LANE_W=16, OP_W=8, MAC_OUT_W=16.
- One sub-module: mac_valid_pipe (parameterised MAC_LAT-deep 1-bit delay line with synchronous clear and an "any pending" output).
- Bench MAC model: sum of N unsigned 8x8 products, truncated to 16 bits, registered MAC_LAT times.

Test Plan:
- Reset then N=4, MAC_LAT=1, len=4, pairs (03,06),(AB,02),(03,06),(AB,02) with in_valid continuous -> one ISSUE with mac_in=0x02AB_0603_02AB_0603; res_valid in cycle 7; res_data=720 (0x2D0).
- len=6, pairs (FF,FF),(FF,FF),(08,05),(03,06),(AB,02),(02,02) -> two ISSUEs, the second with lanes 2-3 zero; group 1 mac_out=64572 (16-bit truncation of 130108); res_data=64918.
- len=0 with start -> DONE the next cycle, res_data=0, no ISSUE, mac_in stays 0.
- len=5 with in_valid toggling every other cycle and res_ready held low for 3 cycles in DONE -> no pair lost or duplicated; res_data stable while waiting; IDLE one cycle after res_ready.
- start pulsed during FILL and in_valid asserted during DRAIN -> both ignored; result unchanged versus the clean run.
- rst asserted in the cycle after ISSUE of a len=8 job -> outputs at reset values next cycle; the returning mac_out is not accumulated; a new len=1 job (03,06) gives res_data=18.
